// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use/WAW scoreboard, multi-cycle EX busy FSM with
// timeout abort, and the 6-bit pipeline stall vector.
module id_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       id_valid,
   input  logic       reg1_read_i,
   input  logic [4:0] reg1_addr_i,
   input  logic       reg2_read_i,
   input  logic [4:0] reg2_addr_i,
   input  logic       wreg_i,
   input  logic [4:0] wd_i,
   input  logic       is_load_i,
   input  logic       is_mc_i,
   input  logic       ld_done_i,
   input  logic [4:0] ld_addr_i,
   input  logic       mc_done_i,
   output logic [5:0] stall_o,
   output logic       issue_o,
   output logic       mc_abort_o,
   output logic [5:0] pend_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pending;
   logic [31:0]      clr_mask;
   logic [31:0]      set_mask;
   logic [31:0]      eff;
   logic             raw_haz;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      clr_mask = '0;
      set_mask = '0;
      if (ld_done_i)
         clr_mask[ld_addr_i] = 1'b1;
      if (issue_o && is_load_i && wreg_i && (wd_i != 5'd0))
         set_mask[wd_i] = 1'b1;
   end

   // A load completing this cycle no longer blocks its consumer.
   assign eff = pending & ~clr_mask;

   assign raw_haz = id_valid & ((reg1_read_i & eff[reg1_addr_i]) |
                                (reg2_read_i & eff[reg2_addr_i]) |
                                (wreg_i      & eff[wd_i]));

   always_comb begin
      stall_o = 6'b000000;
      if (flush)
         stall_o = 6'b000000;
      else if (state != ST_IDLE)
         stall_o = 6'b001111;
      else if (raw_haz)
         stall_o = 6'b000111;
   end

   assign issue_o = id_valid & ~stall_o[2] & ~flush;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending    <= '0;
         state      <= ST_IDLE;
         cnt        <= '0;
         mc_abort_o <= 1'b0;
         pend_cnt_o <= 6'd0;
      end else if (flush) begin
         pending    <= '0;
         state      <= ST_IDLE;
         cnt        <= '0;
         mc_abort_o <= 1'b0;
         pend_cnt_o <= 6'd0;
      end else begin
         // Set is OR-ed after clear, so a same-cycle set of the same register wins.
         pending    <= (pending & ~clr_mask) | set_mask;
         pend_cnt_o <= 6'($countones(pending));
         mc_abort_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (issue_o && is_mc_i) begin
                  state <= ST_BUSY;
                  cnt   <= '0;
               end
            end
            ST_BUSY: begin
               if (mc_done_i) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= ST_ABORT;
                  mc_abort_o <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ABORT: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
